// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I instruction memory: default fault word
// and the load-controller state encoding.
package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } ld_state_t;

endpackage

// File: rtl/instr_mem_array.sv
// Word storage with one synchronous write port and one combinational read port;
// the read port decodes byte addresses and flags misaligned/out-of-range fetches.
module instr_mem_array
  import rv32i_pkg::*;
#(
  parameter int          DEPTH    = 32,
  parameter logic [31:0] NOP_WORD = NOP_INSTR,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic [31:0]   rd_addr,
  output logic [31:0]   rd_data,
  output logic          rd_fault
);

  // Contents start as NOP at elaboration and are never cleared by reset.
  logic [31:0] mem [DEPTH] = '{default: NOP_WORD};

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_fault = (rd_addr[1:0] != 2'b00) || (rd_addr[31:AW+2] != '0);
  assign rd_data  = rd_fault ? NOP_WORD : mem[rd_addr[AW+1:2]];

endmodule

// File: rtl/instr_mem_rv32i.sv
// RV32I instruction memory: fixed-latency fetch port plus a streaming program
// loader that owns the write port while in LOAD.
module instr_mem_rv32i
  import rv32i_pkg::*;
#(
  parameter int          DEPTH    = 32,
  parameter int          RD_LAT   = 1,
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic [31:0]              ADDR,
  output logic                     RSP_VALID,
  output logic [31:0]              INSTR,
  output logic                     FAULT,
  input  logic                     LD_START,
  input  logic                     LD_EN,
  input  logic [31:0]              LD_DATA,
  input  logic                     LD_END,
  output logic [$clog2(DEPTH):0]   LD_CNT,
  output logic                     LD_DONE
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  ld_state_t   state;
  logic        accept;
  logic        wr_en;
  logic        last_word;
  logic [31:0] rd_data;
  logic        rd_fault;
  logic        sel_vld;
  logic [31:0] sel_instr;
  logic        sel_fault;

  assign REQ_READY = (state == ST_RUN) && !LD_START;
  assign accept    = REQ_VALID && REQ_READY;
  assign wr_en     = (state == ST_LOAD) && LD_EN;
  assign last_word = (LD_CNT == CNT_W'(DEPTH - 1));

  instr_mem_array #(
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP_WORD)
  ) u_array (
    .clk      (CLK),
    .wr_en    (wr_en),
    .wr_idx   (LD_CNT[AW-1:0]),
    .wr_data  (LD_DATA),
    .rd_addr  (ADDR),
    .rd_data  (rd_data),
    .rd_fault (rd_fault)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_RUN;
      LD_CNT  <= '0;
      LD_DONE <= 1'b0;
    end else begin
      LD_DONE <= 1'b0;
      case (state)
        ST_RUN: begin
          if (LD_START) begin
            state  <= ST_LOAD;
            LD_CNT <= '0;
          end
        end
        ST_LOAD: begin
          if (LD_EN) LD_CNT <= LD_CNT + CNT_W'(1);
          if (LD_END || (LD_EN && last_word)) begin
            state   <= ST_RUN;
            LD_DONE <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // stage p0: data is captured at acceptance, so a load that starts right
  // after cannot disturb fetches already in flight
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic        vld_p0;
      logic [31:0] instr_p0;
      logic        fault_p0;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) vld_p0 <= 1'b0;
        else        vld_p0 <= accept;
      end

      always_ff @(posedge CLK) begin
        if (accept) begin
          instr_p0 <= rd_data;
          fault_p0 <= rd_fault;
        end
      end

      assign sel_vld   = vld_p0;
      assign sel_instr = instr_p0;
      assign sel_fault = fault_p0;
    end else begin : g_lat1
      assign sel_vld   = accept;
      assign sel_instr = rd_data;
      assign sel_fault = rd_fault;
    end
  endgenerate

  // stage p1: response register, holds the last response while idle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RSP_VALID <= 1'b0;
      INSTR     <= NOP_WORD;
      FAULT     <= 1'b0;
    end else begin
      RSP_VALID <= sel_vld;
      if (sel_vld) begin
        INSTR <= sel_instr;
        FAULT <= sel_fault;
      end
    end
  end

endmodule

// File: doc/instr_mem_rv32i.md
INSTR_MEM_RV32I -- requirements
Module: instr_mem_rv32i

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of 32-bit words; power of two, 4..4096.
REQ-002 SHALL have parameter RD_LAT, default 1: fetch latency in cycles; legal values 1 or 2.
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000013: word returned on fault.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port REQ_VALID  input  1  fetch request.
REQ-007 SHALL have port REQ_READY  output  1  fetch request accepted when high with REQ_VALID.
REQ-008 SHALL have port ADDR  input  32  byte address of the fetch.
REQ-009 SHALL have port RSP_VALID  output  1  INSTR/FAULT valid this cycle.
REQ-010 SHALL have port INSTR  output  32  fetched instruction.
REQ-011 SHALL have port FAULT  output  1  fetch was misaligned or out of range.
REQ-012 SHALL have port LD_START  input  1  pulse: begin program load at word 0.
REQ-013 SHALL have port LD_EN  input  1  LD_DATA valid this cycle.
REQ-014 SHALL have port LD_DATA  input  32  program word to store.
REQ-015 SHALL have port LD_END  input  1  pulse: terminate load early.
REQ-016 SHALL have port LD_CNT  output  clog2(DEPTH)+1  words written in the current/last load.
REQ-017 SHALL have port LD_DONE  output  1  one-cycle pulse when a load finishes.

Function
REQ-018 SHALL implement FSM states RUN and LOAD; the reset state is RUN.
REQ-019 SHALL drive REQ_READY = (state==RUN) && !LD_START.
REQ-020 SHALL move RUN->LOAD on LD_START; LD_START wins over a same-cycle REQ_VALID, and that request is not accepted.
REQ-021 SHALL, in LOAD, on each LD_EN write LD_DATA to word LD_CNT and increment LD_CNT; LD_CNT clears to 0 on LD_START.
REQ-022 SHALL move LOAD->RUN and pulse LD_DONE on the cycle the DEPTH-th word is written, or on LD_END; an LD_EN coincident with LD_END is written first.
REQ-023 SHALL leave words not written by a load unchanged.
REQ-024 SHALL ignore LD_EN in RUN and ignore LD_START in LOAD.
REQ-025 SHALL assert RSP_VALID exactly RD_LAT cycles after each accepted request, one response per request, in order; there is no response backpressure.
REQ-026 SHALL set FAULT=1 and INSTR=NOP_WORD when ADDR[1:0]!=0 or ADDR>=4*DEPTH; otherwise FAULT=0 and INSTR=mem[ADDR[clog2(DEPTH)+1:2]].
REQ-027 SHALL complete requests already in flight at a RUN->LOAD transition with pre-load contents.
REQ-028 SHALL hold INSTR and FAULT stable while RSP_VALID=0, showing the last response.
REQ-029 SHALL initialise every memory word to NOP_WORD at elaboration; memory is never reset.

Reset
REQ-030 SHALL, on RST_N low, force state=RUN, RSP_VALID=0, FAULT=0, INSTR=NOP_WORD, LD_CNT=0, LD_DONE=0, and flush the read pipeline, independent of CLK.
REQ-031 SHALL, on reset during LOAD, abort the load without an LD_DONE pulse and keep all words already written.

Structure
REQ-032 SHALL take NOP_WORD default and the FSM state encoding from the shared package rv32i_pkg.
REQ-033 SHALL place the storage array and address decode in one sub-module, instr_mem_array, with one write port and one read port.

Verification
REQ-034 SHALL cover this case: load 10 words 00100293..00000073, then LD_END -> LD_CNT=10, one LD_DONE pulse, fetches at 0x00/0x24 return 00100293/00000073.
REQ-035 SHALL cover this case: RD_LAT=2, back-to-back requests at 0x0, 0x4, 0x8 -> RSP_VALID on cycles +2,+3,+4 with matching words, FAULT=0.
REQ-036 SHALL cover this case: fetch at 0x6 and at 0x80 (DEPTH=32) -> FAULT=1, INSTR=00000013.
REQ-037 SHALL cover this case: REQ_VALID and LD_START in the same cycle -> REQ_READY=0 that cycle, state=LOAD, no response generated.
REQ-038 SHALL cover this case: write DEPTH=32 words without LD_END -> LD_DONE on the 32nd write, state=RUN, LD_CNT=32.
REQ-039 SHALL cover this case: RST_N low after 5 load words -> no LD_DONE, state=RUN, LD_CNT=0, words 0..4 hold new data, word 5 unchanged.
